// File: rtl/tick_scheduler.sv
// Shared-prescaler timer scheduler: one base tick drives four channels.
// Each channel counts a programmable number of ticks and emits a one-cycle event pulse.
module tick_scheduler #(
    parameter int unsigned PRESCALE = 100000000,
    parameter int unsigned CW       = 8
) (
    input  logic          CLK,
    input  logic          Rst,
    input  logic          hold,
    input  logic          cfg_we,
    input  logic [1:0]    cfg_ch,
    input  logic [CW-1:0] cfg_period,
    input  logic          cfg_mode,
    input  logic          cfg_en,
    output logic          tick,
    output logic [3:0]    ch_pulse,
    output logic [3:0]    ch_active,
    output logic [3:0]    ch_done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ch_state_t;

    localparam logic [31:0] PRE_LAST = 32'(PRESCALE - 1);

    logic [31:0]   pre_cnt;
    ch_state_t     st        [4];
    logic [CW-1:0] remaining [4];
    logic [CW-1:0] period    [4];
    logic [3:0]    mode;

    always_ff @(posedge CLK) begin
        if (Rst) begin
            pre_cnt <= '0;
            tick    <= 1'b0;
        end else if (hold) begin
            tick <= 1'b0;
        end else if (pre_cnt == PRE_LAST) begin
            pre_cnt <= '0;
            tick    <= 1'b1;
        end else begin
            pre_cnt <= pre_cnt + 32'd1;
            tick    <= 1'b0;
        end
    end

    // A config write to a channel takes priority over a coincident tick for that channel only.
    always_ff @(posedge CLK) begin
        if (Rst) begin
            for (int unsigned i = 0; i < 4; i++) begin
                st[i]        <= IDLE;
                remaining[i] <= '0;
                period[i]    <= '0;
            end
            mode      <= '0;
            ch_pulse  <= '0;
            ch_active <= '0;
            ch_done   <= '0;
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                ch_pulse[i] <= 1'b0;
                if (cfg_we && (cfg_ch == 2'(i))) begin
                    period[i]  <= cfg_period;
                    mode[i]    <= cfg_mode;
                    ch_done[i] <= 1'b0;
                    if (cfg_en && (cfg_period != '0)) begin
                        st[i]        <= RUN;
                        remaining[i] <= cfg_period;
                        ch_active[i] <= 1'b1;
                    end else begin
                        st[i]        <= IDLE;
                        remaining[i] <= '0;
                        ch_active[i] <= 1'b0;
                    end
                end else if ((st[i] == RUN) && tick) begin
                    if (remaining[i] > CW'(1)) begin
                        remaining[i] <= remaining[i] - CW'(1);
                    end else begin
                        ch_pulse[i] <= 1'b1;
                        if (mode[i]) begin
                            st[i]        <= DONE;
                            remaining[i] <= '0;
                            ch_active[i] <= 1'b0;
                            ch_done[i]   <= 1'b1;
                        end else begin
                            remaining[i] <= period[i];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/tick_scheduler.md
Name: tick_scheduler

Overview:
Shared-prescaler timer scheduler. One internal prescaler divides CLK into a base tick. Four independent channels share that tick, and each counts a programmable number of ticks to produce one-cycle event pulses. This replaces per-function clock dividers in the lab designs; LED and sequencer logic consumes the ch_pulse strobes as clock enables, and nothing uses them as clocks.

Parameters:
PRESCALE, 100000000, CLK cycles per base tick (must be >= 2).
CW, 8, width of per-channel period/remaining counters.

Ports:
CLK  input  1  system clock; all logic on posedge.
Rst  input  1  synchronous, active-high reset.
hold  input  1  1 = freeze prescaler (no ticks).
cfg_we  input  1  single-cycle channel configuration strobe.
cfg_ch  input  2  channel index 0..3 for cfg_we.
cfg_period  input  CW  period in ticks.
cfg_mode  input  1  0 = periodic, 1 = one-shot.
cfg_en  input  1  1 = start channel, 0 = stop channel.
tick  output  1  registered base tick, one CLK cycle wide.
ch_pulse  output  4  registered per-channel event pulse, one cycle wide.
ch_active  output  4  channel in RUN.
ch_done  output  4  one-shot channel completed.

Behaviour:
- Reset is decided as: reset Rst, synchronous, active-high; clock CLK. On any edge with Rst=1:
  - pre_cnt=0, tick=0, ch_pulse=0, ch_active=0, ch_done=0.
  - All channels go IDLE with remaining=0, period=0, mode=0.
  - Reset overrides cfg_we and hold.
- Prescaler, 32-bit pre_cnt:
  - hold=1: pre_cnt holds its value, tick<=0.
  - Else if pre_cnt==PRESCALE-1: pre_cnt<=0, tick<=1.
  - Else: pre_cnt<=pre_cnt+1, tick<=0.
  - First tick is high in the cycle after the PRESCALE-th post-reset edge; thereafter it is high exactly 1 cycle of every PRESCALE (hold cycles not counted).
- Channel state per channel: IDLE, RUN, DONE. ch_active=1 only in RUN; ch_done=1 only in DONE.
- Config write (cfg_we=1, edge; targets cfg_ch only):
  - Latch period and mode.
  - If cfg_en=1 and cfg_period!=0: RUN, remaining<=cfg_period.
  - If cfg_en=0 or cfg_period==0: IDLE, remaining<=0.
  - ch_done for that channel clears. Writes are accepted in any state (restart/retarget mid-run).
- RUN, on an edge where tick==1 and no write to this channel:
  - remaining>1: remaining<=remaining-1.
  - remaining==1: ch_pulse[ch]<=1.
    - Periodic: remaining<=period, stay in RUN.
    - One-shot: go to DONE, remaining<=0.
- ch_pulse[ch] is 0 on every other edge.
- Latency: the pulse is high in the cycle after the tick cycle that exhausts the count. A period-P channel pulses after every P-th tick. Ticks are counted only if sampled on edges strictly after the enabling write edge.
- Simultaneous cfg_we to a channel and tick: the config wins for that channel. The tick is ignored and no pulse is generated for that channel. Other channels process the tick normally.
- IDLE and DONE ignore ticks.
- Widths: remaining and period are CW bits unsigned; maximum period is 2^CW-1 ticks, with no wrap.

Test Plan:
(PRESCALE=4, CW=8 in simulation)
1. Rst high 3 edges, then low -> all outputs 0 during reset; tick high in cycles 4, 8, 12… after release, each 1 cycle wide.
2. Write ch0 period=3 periodic en=1 -> ch_active[0]=1; ch_pulse[0] high 1 cycle after every 3rd tick (every 12 CLK); no other ch_pulse bits toggle.
3. Write ch1 period=2 one-shot -> exactly one ch_pulse[1], one cycle after the 2nd tick; then ch_done[1]=1, ch_active[1]=0, no further pulses over 10 ticks; rewriting clears ch_done[1].
4. ch2 period=1 periodic; on a tick cycle write ch2 period=5 -> no ch2 pulse that cycle; next ch2 pulse after the 5th subsequent tick.
5. hold=1 for 10 cycles mid-count (pre_cnt=2) -> tick stays 0; after release, the next tick occurs 2 edges later.
6. Write ch3 period=0 en=1 -> ch_active[3]=0. Assert Rst while ch0 and ch1 are running -> all outputs 0 after that edge and no pulses until reconfigured.
